// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage core.
// Drives the enable/flush strobes of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Handles load-use bubbles, EX-resolved branch squashes, main-memory freezes and halt
// retirement. Also keeps a saturating stall counter and a memory-wait watchdog.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned STALL_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_main_mem_read_ex,
  input  logic [2:0]         i_regwrite_adr_ex,
  input  logic [2:0]         i_ra_id,
  input  logic [2:0]         i_rb_id,
  input  logic               i_uses_ra_id,
  input  logic               i_uses_rb_id,
  input  logic               i_branch_taken_ex,
  input  logic               i_mem_req,
  input  logic               i_mem_ack,
  input  logic               i_is_halt_wb,
  output logic               o_en_pc,
  output logic               o_en_ifid,
  output logic               o_en_idex,
  output logic               o_en_exmem,
  output logic               o_en_memwb,
  output logic               o_flush_ifid,
  output logic               o_flush_idex,
  output logic               o_flush_exmem,
  output logic               o_halted,
  output logic               o_mem_timeout,
  output logic [STALL_W-1:0] o_stall_cnt
);

  localparam int unsigned WAIT_W = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
  // wait_cnt value during the last freeze cycle that is still tolerated
  localparam logic [WAIT_W-1:0] WAIT_LAST =
      (MAX_WAIT == 0) ? {WAIT_W{1'b0}} : WAIT_W'(MAX_WAIT - 1);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  logic [0:0]         r_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_mem_timeout;

  logic w_run;
  logic w_lu;
  logic w_frz;
  logic w_timeout;

  assign w_run = (r_state == S_RUN);

  // The load in EX cannot forward to ID in time when ID reads its destination.
  assign w_lu = i_main_mem_read_ex &
                ((i_uses_ra_id & (i_ra_id == i_regwrite_adr_ex)) |
                 (i_uses_rb_id & (i_rb_id == i_regwrite_adr_ex)));

  assign w_frz = i_mem_req & ~i_mem_ack;

  // An ack in the same cycle clears frz, so a late ack never trips the watchdog.
  assign w_timeout = (MAX_WAIT != 0) && w_frz && (r_wait_cnt == WAIT_LAST);

  // Prioritised enable/flush decode; everything idles in reset or once halted.
  always_comb begin
    o_en_pc       = 1'b0;
    o_en_ifid     = 1'b0;
    o_en_idex     = 1'b0;
    o_en_exmem    = 1'b0;
    o_en_memwb    = 1'b0;
    o_flush_ifid  = 1'b0;
    o_flush_idex  = 1'b0;
    o_flush_exmem = 1'b0;
    if (!i_reset && w_run) begin
      if (i_is_halt_wb || w_frz) begin
        // Hold every register; branch/load-use get re-evaluated once unfrozen.
        o_en_pc = 1'b0;
      end else if (i_branch_taken_ex) begin
        // Squash the two younger instructions; any load-use victim dies with them.
        o_en_pc      = 1'b1;
        o_en_ifid    = 1'b1;
        o_en_idex    = 1'b1;
        o_en_exmem   = 1'b1;
        o_en_memwb   = 1'b1;
        o_flush_ifid = 1'b1;
        o_flush_idex = 1'b1;
      end else if (w_lu) begin
        // Hold PC and IF/ID, inject one bubble into ID/EX.
        o_en_idex    = 1'b1;
        o_en_exmem   = 1'b1;
        o_en_memwb   = 1'b1;
        o_flush_idex = 1'b1;
      end else begin
        o_en_pc    = 1'b1;
        o_en_ifid  = 1'b1;
        o_en_idex  = 1'b1;
        o_en_exmem = 1'b1;
        o_en_memwb = 1'b1;
      end
    end
  end

  // Run/halt state: halt retirement or watchdog expiry is terminal until reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_RUN;
    end else if (w_run && (i_is_halt_wb || w_timeout)) begin
      r_state <= S_HALTED;
    end
  end

  // Count consecutive freeze cycles while running.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wait_cnt <= '0;
    end else if (w_run) begin
      r_wait_cnt <= w_frz ? (r_wait_cnt + 1'b1) : '0;
    end
  end

  // Sticky watchdog flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_timeout <= 1'b0;
    end else if (w_run && w_timeout) begin
      r_mem_timeout <= 1'b1;
    end
  end

  // Saturating count of running cycles in which the PC was held.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (w_run && !o_en_pc && (r_stall_cnt != {STALL_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_halted      = (r_state == S_HALTED);
  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default parameters and MAX_WAIT=4/STALL_W=2)
// share one directed stimulus stream; a behavioural model is checked every cycle and a
// set of literal expectations pins the model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ld = 1'b0;
  logic [2:0] rd = 3'd0;
  logic [2:0] ra = 3'd0;
  logic [2:0] rb = 3'd0;
  logic       ua = 1'b0;
  logic       ub = 1'b0;
  logic       br = 1'b0;
  logic       req = 1'b0;
  logic       ack = 1'b0;
  logic       hw = 1'b0;

  logic [1:0]  en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic [1:0]  fl_ifid, fl_idex, fl_exmem, halted, mto;
  logic [15:0] stall_a;
  logic [1:0]  stall_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAX_WAIT(64), .STALL_W(16)) u_a (
    .i_clk(clk), .i_reset(reset), .i_main_mem_read_ex(ld), .i_regwrite_adr_ex(rd),
    .i_ra_id(ra), .i_rb_id(rb), .i_uses_ra_id(ua), .i_uses_rb_id(ub),
    .i_branch_taken_ex(br), .i_mem_req(req), .i_mem_ack(ack), .i_is_halt_wb(hw),
    .o_en_pc(en_pc[0]), .o_en_ifid(en_ifid[0]), .o_en_idex(en_idex[0]),
    .o_en_exmem(en_exmem[0]), .o_en_memwb(en_memwb[0]), .o_flush_ifid(fl_ifid[0]),
    .o_flush_idex(fl_idex[0]), .o_flush_exmem(fl_exmem[0]), .o_halted(halted[0]),
    .o_mem_timeout(mto[0]), .o_stall_cnt(stall_a)
  );

  pipe_hazard_ctrl #(.MAX_WAIT(4), .STALL_W(2)) u_b (
    .i_clk(clk), .i_reset(reset), .i_main_mem_read_ex(ld), .i_regwrite_adr_ex(rd),
    .i_ra_id(ra), .i_rb_id(rb), .i_uses_ra_id(ua), .i_uses_rb_id(ub),
    .i_branch_taken_ex(br), .i_mem_req(req), .i_mem_ack(ack), .i_is_halt_wb(hw),
    .o_en_pc(en_pc[1]), .o_en_ifid(en_ifid[1]), .o_en_idex(en_idex[1]),
    .o_en_exmem(en_exmem[1]), .o_en_memwb(en_memwb[1]), .o_flush_ifid(fl_ifid[1]),
    .o_flush_idex(fl_idex[1]), .o_flush_exmem(fl_exmem[1]), .o_halted(halted[1]),
    .o_mem_timeout(mto[1]), .o_stall_cnt(stall_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state per instance: index 0 = default params, 1 = MAX_WAIT 4 / STALL_W 2
  int unsigned mw[2]      = '{64, 4};
  int unsigned smax[2]    = '{65535, 3};
  bit          m_halt[2]  = '{0, 0};
  bit          m_to[2]    = '{0, 0};
  int unsigned m_stall[2] = '{0, 0};
  int unsigned m_frzrun[2] = '{0, 0};

  // Compare every cycle mid-period, then advance the model as the coming edge will.
  always @(negedge clk) begin : cmp
    logic [7:0]  e;
    logic [7:0]  a;
    logic        lu;
    logic        frz;
    int unsigned act_stall;
    for (int d = 0; d < 2; d++) begin
      lu  = ld && ((ua && ra == rd) || (ub && rb == rd));
      frz = req && !ack;
      // e = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex, fl_exmem}
      if (reset || m_halt[d] || hw || frz) e = 8'b00000_000;
      else if (br)                          e = 8'b11111_110;
      else if (lu)                          e = 8'b00111_010;
      else                                  e = 8'b11111_000;
      a = {en_pc[d], en_ifid[d], en_idex[d], en_exmem[d], en_memwb[d],
           fl_ifid[d], fl_idex[d], fl_exmem[d]};
      act_stall = (d == 0) ? 32'(stall_a) : 32'(stall_b);
      check($sformatf("ctrl%0d", d), 32'(a), 32'(e));
      check($sformatf("halted%0d", d), 32'(halted[d]), 32'(m_halt[d]));
      check($sformatf("timeout%0d", d), 32'(mto[d]), 32'(m_to[d]));
      check($sformatf("stall%0d", d), act_stall, m_stall[d]);
      if (reset) begin
        m_halt[d] = 0; m_to[d] = 0; m_stall[d] = 0; m_frzrun[d] = 0;
      end else if (!m_halt[d]) begin
        if (!e[7] && m_stall[d] < smax[d]) m_stall[d]++;
        if (frz) begin
          m_frzrun[d]++;
          if (mw[d] != 0 && m_frzrun[d] == mw[d]) begin
            m_to[d] = 1; m_halt[d] = 1;
          end
        end else begin
          m_frzrun[d] = 0;
        end
        if (hw) m_halt[d] = 1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    ld = 0; rd = 0; ra = 0; rb = 0; ua = 0; ub = 0; br = 0; req = 0; ack = 0; hw = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick(2);
    reset = 0;
  endtask

  initial begin
    tick(1);
    check("rst_en_pc", 32'(en_pc[0]), 32'd0);
    do_reset();
    #2;
    check("post_rst_en_pc", 32'(en_pc[0]), 32'd1);
    check("post_rst_stall", 32'(stall_a), 32'd0);

    // Load-use on ra
    ld = 1; rd = 3; ra = 3; ua = 1;
    #2;
    check("lu_en_pc", 32'(en_pc[0]), 32'd0);
    check("lu_en_ifid", 32'(en_ifid[0]), 32'd0);
    check("lu_flush_idex", 32'(fl_idex[0]), 32'd1);
    check("lu_en_idex", 32'(en_idex[0]), 32'd1);
    tick();
    check("lu_stall", 32'(stall_a), 32'd1);
    ra = 5;
    #2;
    check("lu_clear_en_pc", 32'(en_pc[0]), 32'd1);
    tick();
    // Match on ra but not used; then load-use via rb
    ra = 3; ua = 0;
    tick();
    rb = 3; ub = 1;
    #2;
    check("lu_rb_en_pc", 32'(en_pc[0]), 32'd0);
    tick();

    // Branch together with load-use
    br = 1;
    #2;
    check("br_flush_ifid", 32'(fl_ifid[0]), 32'd1);
    check("br_flush_idex", 32'(fl_idex[0]), 32'd1);
    check("br_en_pc", 32'(en_pc[0]), 32'd1);
    tick();
    check("br_stall", 32'(stall_a), 32'd2);

    // Five freeze cycles then ack; instance B times out on the fourth
    do_reset();
    req = 1;
    tick(5);
    ack = 1;
    #2;
    check("ack_en_pc", 32'(en_pc[0]), 32'd1);
    tick();
    check("frz_stall", 32'(stall_a), 32'd5);
    check("frz_timeout_a", 32'(mto[0]), 32'd0);
    check("wd_halted_b", 32'(halted[1]), 32'd1);
    check("wd_timeout_b", 32'(mto[1]), 32'd1);
    idle();
    br = 1; ld = 1; rd = 2; ra = 2; ua = 1;
    #2;
    check("halted_b_en_pc", 32'(en_pc[1]), 32'd0);
    check("halted_b_flush", 32'(fl_ifid[1]), 32'd0);
    tick(2);

    // Ack on the last tolerated cycle avoids the timeout; a fresh run then expires
    do_reset();
    req = 1;
    tick(3);
    ack = 1;
    tick();
    check("late_ack_timeout_b", 32'(mto[1]), 32'd0);
    check("late_ack_halted_b", 32'(halted[1]), 32'd0);
    ack = 0;
    tick(3);
    check("rearm_halted_b", 32'(halted[1]), 32'd0);
    tick();
    check("rearm_timeout_b", 32'(mto[1]), 32'd1);
    req = 0;
    tick();

    // Halt in WB coincident with a freeze
    do_reset();
    hw = 1; req = 1;
    #2;
    check("halt_en_pc", 32'(en_pc[0]), 32'd0);
    tick();
    check("halt_halted", 32'(halted[0]), 32'd1);
    check("halt_timeout", 32'(mto[0]), 32'd0);
    idle();
    tick();
    reset = 1;
    tick();
    reset = 0;
    #2;
    check("rst2_halted", 32'(halted[0]), 32'd0);
    check("rst2_stall", 32'(stall_a), 32'd0);
    check("rst2_en_pc", 32'(en_pc[0]), 32'd1);

    // Saturation of the narrow counter
    ld = 1; rd = 6; ra = 6; ua = 1;
    tick(5);
    check("sat_stall_b", 32'(stall_b), 32'd3);
    check("sat_stall_a", 32'(stall_a), 32'd5);
    idle();
    tick(2);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage core's pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Computes per-stage enable and flush strobes, taking into account:
  - load-use hazards
  - taken branches resolved in EX
  - multi-cycle main-memory waits
  - halt retirement
- Keeps a saturating stall counter and a memory-timeout watchdog.
- Sits beside the decoder. Its outputs drive the en_*/flush_* inputs of the pipeline register blocks directly.

Parameters:
- MAX_WAIT, 64: consecutive memory-freeze cycles before timeout; 0 disables the watchdog.
- STALL_W, 16: width of stall_cnt.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- main_mem_read_ex  in  1  instruction in EX is a load
- regwrite_adr_ex  in  3  destination register of the instruction in EX
- ra_id  in  3  source register A of the instruction in ID
- rb_id  in  3  source register B of the instruction in ID
- uses_ra_id  in  1  ID instruction reads ra_id
- uses_rb_id  in  1  ID instruction reads rb_id
- branch_taken_ex  in  1  taken branch/jump resolved in EX
- mem_req  in  1  MEM stage is accessing main memory this cycle
- mem_ack  in  1  main memory completes the access this cycle
- is_halt_wb  in  1  HLT instruction is in WB
- en_pc, en_ifid, en_idex, en_exmem, en_memwb  out  1 each  register enables
- flush_ifid, flush_idex, flush_exmem  out  1 each  synchronous clear (bubble insert)
- halted  out  1  core stopped
- mem_timeout  out  1  sticky watchdog flag
- stall_cnt  out  STALL_W  cycles the PC was held while running

Behaviour:
- Clock/reset: single clock clk; reset is synchronous, active-high.
- Reset:
  - state=RUN, wait_cnt=0, stall_cnt=0, halted=0, mem_timeout=0.
  - While reset=1, all en_*=0 and flush_*=0.
- States:
  - RUN: normal operation.
  - HALTED: terminal; exits only via reset.
- Hazard terms, all combinational from inputs and state:
  - lu = main_mem_read_ex & ((uses_ra_id & ra_id==regwrite_adr_ex) | (uses_rb_id & rb_id==regwrite_adr_ex))
  - frz = mem_req & ~mem_ack
- Output priority in RUN, highest first:
  1. is_halt_wb: all en_*=0, no flush. Next state HALTED.
  2. frz: all en_*=0, no flush. Pipeline is frozen; branch/lu are ignored this cycle and re-evaluated once frz drops, because the registers hold their contents.
  3. branch_taken_ex: all en_*=1, flush_ifid=1, flush_idex=1. lu is ignored because the dependent instruction is squashed.
  4. lu: en_pc=0, en_ifid=0, flush_idex=1, en_idex/en_exmem/en_memwb=1. Exactly one bubble; the hazard clears naturally the next cycle.
  5. Otherwise: all en_*=1, flushes 0.
- flush_exmem is reserved and always 0 in this revision (tied low, but the port is kept).
- Default en_* with no hazard is 1.
- Watchdog:
  - wait_cnt increments on each RUN cycle with frz=1 and clears on any RUN cycle with frz=0.
  - If MAX_WAIT≠0 and frz=1 while wait_cnt==MAX_WAIT-1 (i.e. the MAX_WAIT-th consecutive freeze cycle): next state HALTED and mem_timeout←1.
  - mem_ack arriving on that same cycle makes frz=0, so no timeout.
- HALTED:
  - All en_*=0, flush_*=0, halted=1 (registered: asserted the cycle after entry).
  - All inputs are ignored. mem_timeout holds.
- stall_cnt:
  - +1 on each RUN cycle with en_pc=0 (halt cycle, freeze, or load-use).
  - Saturates at all-ones and does not count in HALTED.
- Latency: control outputs are combinational (same cycle); halted and mem_timeout are registered (+1 cycle).
- wait_cnt width is clog2(MAX_WAIT+1), minimum 1.

Test Plan:
- Load-use: main_mem_read_ex=1, regwrite_adr_ex=3, ra_id=3, uses_ra_id=1 for one cycle -> en_pc=0, en_ifid=0, flush_idex=1, en_idex=1; stall_cnt 0→1; next cycle with ra_id≠3, all en=1.
- Branch + load-use in the same cycle -> flush_ifid=1, flush_idex=1, en_pc=1; stall_cnt unchanged.
- mem_req=1, mem_ack=0 for 5 cycles, then ack -> all en=0 for 5 cycles; in the ack cycle all en=1; stall_cnt=5; mem_timeout=0.
- MAX_WAIT=4, mem_req=1, ack never -> freeze 4 cycles; cycle 5: halted=1, mem_timeout=1; later inputs (branch, lu) produce no en/flush activity.
- is_halt_wb=1 coincident with mem_req & ~mem_ack -> all en=0; next cycle halted=1, mem_timeout=0; reset pulse -> halted=0, stall_cnt=0, all en=1 after reset drops.
- STALL_W=2: 5 load-use cycles -> stall_cnt saturates at 3.
